// File: rtl/mul16_seq_ctrl.sv
// ---------------------------------------------------------------------------
// mul16_seq_ctrl
//
// Computes a 16x16 unsigned product with one external, shared, combinational
// 8x8 multiplier. It feeds one byte pair per cycle and shift-accumulates the
// partial products into a 32-bit register. Mode 1 computes a single 8x8
// product of the low bytes.
//
// Ports:
//   clk, rst_n           - clock; synchronous active-low reset
//   in_valid/in_ready    - operand handshake (in_a, in_b, in_mode)
//   in_mode              - 0: 16x16, 1: 8x8 on in_a[7:0] * in_b[7:0]
//   out_valid/out_ready  - result handshake (out_p)
//   mul_a, mul_b, mul_p  - shared multiplier operands / product (same cycle)
//   mul_en               - high while this block owns the multiplier
// ---------------------------------------------------------------------------
module mul16_seq_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_a,
  input  logic [15:0] in_b,
  input  logic        in_mode,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_p,
  output logic [7:0]  mul_a,
  output logic [7:0]  mul_b,
  input  logic [15:0] mul_p,
  output logic        mul_en
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  step_q,  step_d;
  logic [31:0] acc_q,   acc_d;
  logic [15:0] a_q,     a_d;
  logic [15:0] b_q,     b_d;
  logic        mode_q,  mode_d;
  logic [31:0] pp_shifted;

  // Handshake outputs come from registered state only; rst_n gating keeps
  // the block quiet while reset is held.
  assign in_ready  = rst_n && (state_q == S_IDLE);
  assign out_valid = rst_n && (state_q == S_DONE);
  assign out_p     = rst_n ? acc_q : 32'h0000_0000;

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (!rst_n) begin
      state_q <= S_IDLE;
      step_q  <= 2'd0;
      acc_q   <= 32'h0000_0000;
      a_q     <= 16'h0000;
      b_q     <= 16'h0000;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      acc_q   <= acc_d;
      a_q     <= a_d;
      b_q     <= b_d;
      mode_q  <= mode_d;
    end
  end

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path
    // through the case leaves one unassigned and no latch is inferred.
    state_d    = state_q;
    step_d     = step_q;
    acc_d      = acc_q;
    a_d        = a_q;
    b_d        = b_q;
    mode_d     = mode_q;
    mul_a      = 8'h00;
    mul_b      = 8'h00;
    mul_en     = 1'b0;
    pp_shifted = 32'h0000_0000;

    unique case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready) begin
          a_d     = in_a;
          b_d     = in_b;
          mode_d  = in_mode;
          acc_d   = 32'h0000_0000;
          step_d  = 2'd0;
          state_d = S_MUL;
        end
      end

      S_MUL: begin
        mul_en = 1'b1;
        // step[1] picks the a byte, step[0] the b byte:
        // 0: lo*lo, 1: lo*hi, 2: hi*lo, 3: hi*hi.
        mul_a  = step_q[1] ? a_q[15:8] : a_q[7:0];
        mul_b  = step_q[0] ? b_q[15:8] : b_q[7:0];
        unique case (step_q)
          2'd0:    pp_shifted = {16'h0000, mul_p};
          2'd3:    pp_shifted = {mul_p, 16'h0000};
          default: pp_shifted = {8'h00, mul_p, 8'h00};
        endcase
        // Worst case sum is 0xFFFE0001, so 32 bits never wrap.
        acc_d  = acc_q + pp_shifted;
        step_d = step_q + 2'd1;
        if (mode_q || (step_q == 2'd3)) begin
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // The multiplier is released as soon as reset is asserted, not one
    // edge later.
    if (!rst_n) begin
      mul_en = 1'b0;
      mul_a  = 8'h00;
      mul_b  = 8'h00;
    end
  end

endmodule

// File: tb/tb_mul16_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mul16_seq_ctrl
//
// Bench for mul16_seq_ctrl. It plays the shared 8x8 multiplier itself
// (mul_p = mul_a * mul_b). A transaction-level model tracks each operation
// as "expected product + list of byte pairs still to be issued". A negedge
// compare process checks every output against that model. Directed
// sequences pin results, latencies, spacing and the operand byte order to
// hand-computed literals. A randomized phase follows.
// ---------------------------------------------------------------------------
module tb_mul16_seq_ctrl;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic        in_mode;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_p;
  logic [7:0]  mul_a;
  logic [7:0]  mul_b;
  logic [15:0] mul_p;
  logic        mul_en;

  int n_checks = 0;
  int n_errors = 0;

  mul16_seq_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_p     (out_p),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_p     (mul_p),
    .mul_en    (mul_en)
  );

  // Shared multiplier, outside the controller.
  assign mul_p = 16'(mul_a) * 16'(mul_b);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  localparam int PH_IDLE = 0;
  localparam int PH_BUSY = 1;
  localparam int PH_DONE = 2;

  int          m_phase  = PH_IDLE;
  logic [31:0] m_res    = 32'h0;
  logic [15:0] m_pairs[$];
  bit          model_ok = 1'b0;
  int          cyc_cnt  = 0;
  int          accept_cyc[$];

  always @(posedge clk) begin
    cyc_cnt++;
    if (!rst_n) begin
      m_phase  = PH_IDLE;
      m_res    = 32'h0;
      m_pairs.delete();
      model_ok = 1'b1;
    end else begin
      case (m_phase)
        PH_IDLE: if (in_valid) begin
          m_pairs.delete();
          if (in_mode) begin
            m_res = {24'h0, in_a[7:0]} * {24'h0, in_b[7:0]};
            m_pairs.push_back({in_a[7:0], in_b[7:0]});
          end else begin
            m_res = {16'h0, in_a} * {16'h0, in_b};
            m_pairs.push_back({in_a[7:0],  in_b[7:0]});
            m_pairs.push_back({in_a[7:0],  in_b[15:8]});
            m_pairs.push_back({in_a[15:8], in_b[7:0]});
            m_pairs.push_back({in_a[15:8], in_b[15:8]});
          end
          accept_cyc.push_back(cyc_cnt);
          m_phase = PH_BUSY;
        end
        PH_BUSY: begin
          void'(m_pairs.pop_front());
          if (m_pairs.size() == 0) m_phase = PH_DONE;
        end
        default: if (out_ready) m_phase = PH_IDLE;
      endcase
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (model_ok) begin
      logic [15:0] exp_pair;
      exp_pair = (rst_n && m_phase == PH_BUSY) ? m_pairs[0] : 16'h0000;
      check("cmp in_ready",  32'(in_ready),  32'(rst_n && m_phase == PH_IDLE));
      check("cmp out_valid", 32'(out_valid), 32'(rst_n && m_phase == PH_DONE));
      check("cmp mul_en",    32'(mul_en),    32'(rst_n && m_phase == PH_BUSY));
      check("cmp mul_ab",    32'({mul_a, mul_b}), 32'(exp_pair));
      if (!rst_n)                   check("cmp out_p reset", out_p, 32'h0);
      else if (m_phase == PH_DONE)  check("cmp out_p", out_p, m_res);
    end
  end

  // ---------------- directed helpers ----------------
  logic [15:0] seq[4];
  int          n_en;

  // Called #1 after the accept edge; returns cycles until out_valid.
  task automatic wait_valid(output int cyc);
    cyc  = 0;
    n_en = 0;
    while (cyc < 20) begin
      if (out_valid) break;
      if (mul_en) begin
        if (n_en < 4) seq[n_en] = {mul_a, mul_b};
        n_en++;
      end
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic m,
                       input logic [31:0] exp, input int lat, input string nm);
    int cyc;
    in_a = a; in_b = b; in_mode = m; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_a = 16'($urandom);
    in_b = 16'($urandom);
    in_mode = 1'($urandom);
    wait_valid(cyc);
    check({nm, " latency"}, 32'(cyc), 32'(lat));
    check({nm, " out_p"}, out_p, exp);
    @(posedge clk); #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int cyc;
    rst_n = 1'b0; in_valid = 1'b0; in_a = 16'h0; in_b = 16'h0;
    in_mode = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset in_ready",  32'(in_ready),  32'h0);
    check("reset out_valid", 32'(out_valid), 32'h0);
    check("reset mul_en",    32'(mul_en),    32'h0);
    rst_n = 1'b1;
    #1;
    check("post-reset in_ready", 32'(in_ready), 32'h1);
    check("post-reset out_p",    out_p,         32'h0);

    // Basic 16x16 with byte order check.
    do_op(16'h1234, 16'h5678, 1'b0, 32'h0626_0060, 4, "1234x5678");
    check("seq n_en", 32'(n_en), 32'd4);
    check("seq step0", 32'(seq[0]), 32'h3478);
    check("seq step1", 32'(seq[1]), 32'h3456);
    check("seq step2", 32'(seq[2]), 32'h1278);
    check("seq step3", 32'(seq[3]), 32'h1256);

    do_op(16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE_0001, 4, "FFFFxFFFF");

    do_op(16'hAAFF, 16'h55FF, 1'b1, 32'h0000_FE01, 1, "mode1");
    check("mode1 n_en", 32'(n_en), 32'd1);
    check("mode1 pair", 32'(seq[0]), 32'hFFFF);

    // Backpressure with a pending request held during DONE.
    in_a = 16'h00FF; in_b = 16'h0101; in_mode = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_a = 16'h0003; in_b = 16'h0005;
    wait_valid(cyc);
    check("bp latency", 32'(cyc), 32'd4);
    check("bp out_p", out_p, 32'h0000_FFFF);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("bp hold out_p",     out_p,             32'h0000_FFFF);
      check("bp hold in_ready",  32'(in_ready),     32'h0);
      check("bp hold out_valid", 32'(out_valid),    32'h1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp back to idle", 32'(in_ready), 32'h1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_valid(cyc);
    check("bp next latency", 32'(cyc), 32'd4);
    check("bp next out_p", out_p, 32'h0000_000F);
    @(posedge clk); #1;

    // Reset during step2.
    in_a = 16'h1234; in_b = 16'h5678; in_mode = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    check("abort at step2", 32'({mul_a, mul_b}), 32'h1278);
    rst_n = 1'b0;
    #1;
    check("abort mul_en gated", 32'(mul_en), 32'h0);
    @(posedge clk); #1;
    check("abort out_p",     out_p,          32'h0);
    check("abort out_valid", 32'(out_valid), 32'h0);
    rst_n = 1'b1;
    #1;
    check("abort idle", 32'(in_ready), 32'h1);
    check("abort mul_en", 32'(mul_en), 32'h0);
    do_op(16'h0011, 16'h0022, 1'b0, 32'h0000_0242, 4, "after abort");

    // Back-to-back spacing.
    accept_cyc.delete();
    do_op(16'h0000, 16'hFFFF, 1'b0, 32'h0000_0000, 4, "b2b 0");
    do_op(16'h0001, 16'hFFFF, 1'b0, 32'h0000_FFFF, 4, "b2b 1");
    do_op(16'h8000, 16'h0002, 1'b0, 32'h0001_0000, 4, "b2b 2");
    check("b2b accepts", 32'(accept_cyc.size()), 32'd3);
    if (accept_cyc.size() == 3) begin
      check("b2b spacing 1", 32'(accept_cyc[1] - accept_cyc[0]), 32'd6);
      check("b2b spacing 2", 32'(accept_cyc[2] - accept_cyc[1]), 32'd6);
    end
    accept_cyc.delete();
    do_op(16'h1203, 16'h3404, 1'b1, 32'h0000_000C, 1, "m1 b2b 0");
    do_op(16'h00FE, 16'h0002, 1'b1, 32'h0000_01FC, 1, "m1 b2b 1");
    if (accept_cyc.size() == 2)
      check("m1 spacing", 32'(accept_cyc[1] - accept_cyc[0]), 32'd3);
    else
      check("m1 accepts", 32'(accept_cyc.size()), 32'd2);

    // Randomized traffic, occasional reset; compare process does the checking.
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk); #1;
      in_valid  = ($urandom_range(0, 2) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      in_a      = 16'($urandom);
      in_b      = 16'($urandom);
      in_mode   = ($urandom_range(0, 3) == 0);
      if (($urandom_range(0, 15) == 0) && (i % 4 == 0)) begin
        in_a = 16'hFFFF; in_b = 16'hFFFF;
      end
      rst_n     = ($urandom_range(0, 79) != 0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    check("drain idle", 32'(in_ready), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
